// File: rtl/sha256_round_ctrl.sv
`timescale 1ns/1ps
// SHA-256 compression sequencer: block handshake, 64-round stepping,
// working/hash register enables and digest hand-off.
module sha256_round_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       blk_valid_i,
  input  logic       first_blk_i,
  input  logic       last_blk_i,
  output logic       blk_ready_o,
  output logic       msg_load_o,
  input  logic       abort_i,
  output logic       reg_start_o,
  output logic       init_sel_o,
  output logic       hash_init_o,
  output logic       hash_upd_o,
  output logic [5:0] round_o,
  output logic       w_sel_o,
  output logic       w_shift_o,
  output logic       busy_o,
  output logic       digest_valid_o,
  input  logic       digest_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [5:0] r_t;
  logic       r_first;
  logic       r_last;
  logic       r_start;
  logic       r_isel;
  logic       r_upd;
  logic       r_wshift;
  logic       r_busy;
  logic       r_dv;

  logic       w_accept;
  logic       w_abort;

  assign blk_ready_o = (r_state == S_IDLE) & ~RST;
  assign w_accept    = blk_ready_o & blk_valid_i;
  assign w_abort     = abort_i & (r_state inside {S_INIT, S_ROUND, S_UPDATE});

  assign msg_load_o     = w_accept;
  assign reg_start_o    = r_start;
  assign init_sel_o     = r_isel;
  // H is IV only on a first block; the datapath muxes IV in that cycle
  assign hash_init_o    = r_isel & r_first;
  assign hash_upd_o     = r_upd & ~abort_i;
  assign round_o        = r_t;
  assign w_sel_o        = (r_t >= 6'd16);
  assign w_shift_o      = r_wshift;
  assign busy_o         = r_busy;
  assign digest_valid_o = r_dv;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_t      <= '0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_start  <= 1'b0;
      r_isel   <= 1'b0;
      r_upd    <= 1'b0;
      r_wshift <= 1'b0;
      r_busy   <= 1'b0;
      r_dv     <= 1'b0;
    end else begin
      r_start  <= 1'b0;
      r_isel   <= 1'b0;
      r_upd    <= 1'b0;
      r_wshift <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_t     <= '0;
        r_first <= 1'b0;
        r_last  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state <= S_INIT;
              r_first <= first_blk_i;
              r_last  <= last_blk_i;
              r_start <= 1'b1;
              r_isel  <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_INIT: begin
            r_state  <= S_ROUND;
            r_t      <= '0;
            r_start  <= 1'b1;
            r_wshift <= 1'b1;
          end
          S_ROUND: begin
            if (r_t == 6'd63) begin
              r_state <= S_UPDATE;
              r_t     <= '0;
              r_upd   <= 1'b1;
            end else begin
              r_t      <= r_t + 6'd1;
              r_start  <= 1'b1;
              r_wshift <= 1'b1;
            end
          end
          S_UPDATE: begin
            if (r_last) begin
              r_state <= S_DONE;
              r_dv    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_DONE: begin
            if (digest_ack_i) begin
              r_state <= S_IDLE;
              r_dv    <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_dv    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
`timescale 1ns/1ps
// Bench for sha256_round_ctrl: vector table, corner sequences, a small
// SHA-256 datapath driven by the controller, and a randomized model check.
module tb_sha256_round_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       blk_valid_i, first_blk_i, last_blk_i, abort_i, digest_ack_i;
  logic       blk_ready_o, msg_load_o, reg_start_o, init_sel_o;
  logic       hash_init_o, hash_upd_o, w_sel_o, w_shift_o;
  logic       busy_o, digest_valid_o;
  logic [5:0] round_o;

  sha256_round_ctrl dut (
    .CLK(CLK), .RST(RST),
    .blk_valid_i(blk_valid_i), .first_blk_i(first_blk_i),
    .last_blk_i(last_blk_i), .blk_ready_o(blk_ready_o),
    .msg_load_o(msg_load_o), .abort_i(abort_i),
    .reg_start_o(reg_start_o), .init_sel_o(init_sel_o),
    .hash_init_o(hash_init_o), .hash_upd_o(hash_upd_o),
    .round_o(round_o), .w_sel_o(w_sel_o), .w_shift_o(w_shift_o),
    .busy_o(busy_o), .digest_valid_o(digest_valid_o),
    .digest_ack_i(digest_ack_i)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] M2 [14] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071
  };

  localparam logic [255:0] EXP_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EXP_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bs0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction
  function automatic logic [31:0] bs1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Datapath obeying the controller's enables
  logic [31:0] bus [16];
  logic [31:0] W [16];
  logic [31:0] V [8];
  logic [31:0] H [8];
  logic [31:0] wt, t1, t2;
  logic [255:0] w_hcat;

  assign w_hcat = {H[0], H[1], H[2], H[3], H[4], H[5], H[6], H[7]};

  always_comb begin
    wt = w_sel_o ? (ss1(W[14]) + W[9] + ss0(W[1]) + W[0]) : W[0];
    t1 = V[7] + bs1(V[4]) + ((V[4] & V[5]) ^ (~V[4] & V[6])) + K[round_o] + wt;
    t2 = bs0(V[0]) + ((V[0] & V[1]) ^ (V[0] & V[2]) ^ (V[1] & V[2]));
  end

  always @(posedge CLK) begin
    if (msg_load_o) begin
      for (int i = 0; i < 16; i++) W[i] <= bus[i];
    end else if (w_shift_o) begin
      for (int i = 0; i < 15; i++) W[i] <= W[i+1];
      W[15] <= wt;
    end
    if (reg_start_o) begin
      if (init_sel_o) begin
        for (int i = 0; i < 8; i++) V[i] <= hash_init_o ? IV[i] : H[i];
      end else begin
        V[0] <= t1 + t2;
        V[1] <= V[0];
        V[2] <= V[1];
        V[3] <= V[2];
        V[4] <= V[3] + t1;
        V[5] <= V[4];
        V[6] <= V[5];
        V[7] <= V[6];
      end
    end
    if (hash_init_o) begin
      for (int i = 0; i < 8; i++) H[i] <= IV[i];
    end else if (hash_upd_o) begin
      for (int i = 0; i < 8; i++) H[i] <= H[i] + V[i];
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {blk_ready_o, msg_load_o, reg_start_o, init_sel_o, hash_init_o,
            hash_upd_o, round_o, w_sel_o, w_shift_o, busy_o, digest_valid_o};
  endfunction

  function automatic logic [15:0] pk(
    input logic rdy, ld, st, is, hi, up, input int rd,
    input logic ws, wsh, bz, dv);
    return {rdy, ld, st, is, hi, up, 6'(rd), ws, wsh, bz, dv};
  endfunction

  task automatic set_abc();
    for (int i = 0; i < 16; i++) bus[i] = '0;
    bus[0]  = 32'h61626380;
    bus[15] = 32'h00000018;
  endtask
  task automatic set_b1();
    for (int i = 0; i < 14; i++) bus[i] = M2[i];
    bus[14] = 32'h80000000;
    bus[15] = '0;
  endtask
  task automatic set_b2();
    for (int i = 0; i < 16; i++) bus[i] = '0;
    bus[15] = 32'h000001c0;
  endtask

  task automatic offer(input logic f, l, input string nm);
    @(negedge CLK);
    blk_valid_i = 1'b1;
    first_blk_i = f;
    last_blk_i  = l;
    #1;
    check(nm, msg_load_o, 1'b1);
    @(posedge CLK);
    #1;
    blk_valid_i = 1'b0;
    first_blk_i = 1'b0;
    last_blk_i  = 1'b0;
  endtask

  task automatic wait_round(input int r, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge CLK);
      #1;
      if (reg_start_o && !init_sel_o && round_o == 6'(r)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_upd(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge CLK);
      #1;
      if (hash_upd_o) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_msg(input logic f, l, input string nm);
    bit ok;
    ok = 1'b0;
    offer(f, l, {nm, "_load"});
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      #1;
      if (digest_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    check({nm, "_done"}, ok, 1'b1);
    digest_ack_i = 1'b1;
    @(negedge CLK);
    digest_ack_i = 1'b0;
    #1;
    check({nm, "_idle"}, outs(), pk(1,0,0,0,0,0,0,0,0,0,0));
  endtask

  typedef struct {
    int          cyc;
    logic        v, f, l, ab, ack;
    logic [15:0] exp;
  } vec_t;

  vec_t         tbl [$];
  logic [255:0] hsave;
  bit           ok;
  int           acc, a1, hi_cnt, dv_cyc, idx;
  int           mmode, mk;
  logic         mf, ml, inb;
  logic [15:0]  e;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{cyc:0,  v:1, f:1, l:1, ab:0, ack:0, exp:pk(1,1,0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{cyc:1,  v:0, f:0, l:0, ab:0, ack:0, exp:pk(0,0,1,1,1,0,0,0,0,1,0)});
    tbl.push_back('{cyc:2,  v:0, f:0, l:0, ab:0, ack:0, exp:pk(0,0,1,0,0,0,0,0,1,1,0)});
    tbl.push_back('{cyc:17, v:0, f:0, l:0, ab:0, ack:0, exp:pk(0,0,1,0,0,0,15,0,1,1,0)});
    tbl.push_back('{cyc:18, v:0, f:0, l:0, ab:0, ack:0, exp:pk(0,0,1,0,0,0,16,1,1,1,0)});
    tbl.push_back('{cyc:30, v:1, f:1, l:0, ab:0, ack:0, exp:pk(0,0,1,0,0,0,28,1,1,1,0)});
    tbl.push_back('{cyc:40, v:0, f:0, l:0, ab:0, ack:1, exp:pk(0,0,1,0,0,0,38,1,1,1,0)});
    tbl.push_back('{cyc:65, v:0, f:0, l:0, ab:0, ack:0, exp:pk(0,0,1,0,0,0,63,1,1,1,0)});
    tbl.push_back('{cyc:66, v:0, f:0, l:0, ab:0, ack:0, exp:pk(0,0,0,0,0,1,0,0,0,1,0)});
    tbl.push_back('{cyc:67, v:0, f:0, l:0, ab:0, ack:0, exp:pk(0,0,0,0,0,0,0,0,0,1,1)});
    tbl.push_back('{cyc:72, v:1, f:1, l:1, ab:1, ack:0, exp:pk(0,0,0,0,0,0,0,0,0,1,1)});
    tbl.push_back('{cyc:77, v:0, f:0, l:0, ab:0, ack:1, exp:pk(0,0,0,0,0,0,0,0,0,1,1)});
    tbl.push_back('{cyc:78, v:0, f:0, l:0, ab:1, ack:0, exp:pk(1,0,0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{cyc:79, v:0, f:0, l:0, ab:0, ack:0, exp:pk(1,0,0,0,0,0,0,0,0,0,0)});

    RST = 1'b1;
    blk_valid_i = 1'b1;
    first_blk_i = 1'b1;
    last_blk_i = 1'b1;
    abort_i = 1'b0;
    digest_ack_i = 1'b0;
    set_abc();
    repeat (2) @(negedge CLK);
    #1;
    check("reset_outs", outs(), '0);
    @(negedge CLK);
    RST = 1'b0;
    blk_valid_i = 1'b0;
    #1;
    check("reset_release", outs(), pk(1,0,0,0,0,0,0,0,0,0,0));

    // "abc" block, digest hold and ignored inputs
    idx = 0;
    for (int c = 0; c <= tbl[tbl.size()-1].cyc; c++) begin
      @(negedge CLK);
      blk_valid_i = 1'b0;
      first_blk_i = 1'b0;
      last_blk_i = 1'b0;
      abort_i = 1'b0;
      digest_ack_i = 1'b0;
      if (tbl[idx].cyc == c) begin
        blk_valid_i = tbl[idx].v;
        first_blk_i = tbl[idx].f;
        last_blk_i = tbl[idx].l;
        abort_i = tbl[idx].ab;
        digest_ack_i = tbl[idx].ack;
      end
      #1;
      if (tbl[idx].cyc == c) begin
        check($sformatf("vec_cyc%0d", c), outs(), tbl[idx].exp);
        idx++;
      end
    end
    abort_i = 1'b0;
    check("abc_digest", w_hcat, EXP_ABC);

    // two-block message offered continuously
    set_b1();
    acc = 0;
    a1 = -1;
    hi_cnt = 0;
    dv_cyc = -1;
    for (int c = 0; c <= 140; c++) begin
      @(negedge CLK);
      if (acc >= 1) set_b2();
      blk_valid_i = (acc < 2);
      first_blk_i = (acc == 0);
      last_blk_i = (acc >= 1);
      #1;
      if (msg_load_o) begin
        if (acc == 1) a1 = c;
        acc++;
      end
      if (hash_init_o) hi_cnt++;
      if (digest_valid_o && dv_cyc < 0) dv_cyc = c;
    end
    blk_valid_i = 1'b0;
    check("two_accept2_cyc", a1, 67);
    check("two_hash_init_cnt", hi_cnt, 1);
    check("two_dv_cyc", dv_cyc, 134);
    check("two_digest", w_hcat, EXP_TWO);
    digest_ack_i = 1'b1;
    @(negedge CLK);
    digest_ack_i = 1'b0;
    #1;
    check("two_ack_idle", outs(), pk(1,0,0,0,0,0,0,0,0,0,0));

    // abort at round 30: H must survive untouched
    set_abc();
    hsave = w_hcat;
    offer(1'b0, 1'b1, "ab30_load");
    wait_round(30, ok);
    check("ab30_reach", ok, 1'b1);
    abort_i = 1'b1;
    @(negedge CLK);
    abort_i = 1'b0;
    #1;
    check("ab30_idle", outs(), pk(1,0,0,0,0,0,0,0,0,0,0));
    check("ab30_H", w_hcat, hsave);

    // abort in the UPDATE cycle
    offer(1'b0, 1'b1, "abu_load");
    wait_upd(ok);
    check("abu_reach", ok, 1'b1);
    abort_i = 1'b1;
    #1;
    check("abu_hash_upd", hash_upd_o, 1'b0);
    @(negedge CLK);
    abort_i = 1'b0;
    #1;
    check("abu_idle", outs(), pk(1,0,0,0,0,0,0,0,0,0,0));
    check("abu_H", w_hcat, hsave);

    // async reset at round 40
    offer(1'b1, 1'b1, "rst40_load");
    wait_round(40, ok);
    check("rst40_reach", ok, 1'b1);
    RST = 1'b1;
    blk_valid_i = 1'b1;
    #1;
    check("rst40_outs", outs(), '0);
    @(negedge CLK);
    #1;
    check("rst40_hold", outs(), '0);
    @(negedge CLK);
    RST = 1'b0;
    blk_valid_i = 1'b0;
    #1;
    check("rst40_release", outs(), pk(1,0,0,0,0,0,0,0,0,0,0));
    run_msg(1'b1, 1'b1, "rst40_fresh");
    check("rst40_digest", w_hcat, EXP_ABC);

    // randomized traffic against a cycles-since-accept model
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    mmode = 0;
    mk = 0;
    mf = 1'b0;
    ml = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      blk_valid_i = ($urandom_range(0, 1) == 1);
      first_blk_i = ($urandom_range(0, 1) == 1);
      last_blk_i = ($urandom_range(0, 1) == 1);
      abort_i = ($urandom_range(0, 63) == 0);
      digest_ack_i = ($urandom_range(0, 3) == 0);
      #1;
      inb = (mmode == 1);
      e = pk(mmode == 0, (mmode == 0) && blk_valid_i,
             inb && mk <= 65, inb && mk == 1, inb && mk == 1 && mf,
             inb && mk == 66 && !abort_i,
             (inb && mk >= 2 && mk <= 65) ? mk - 2 : 0,
             inb && mk >= 18 && mk <= 65, inb && mk >= 2 && mk <= 65,
             mmode != 0, mmode == 2);
      check($sformatf("rand_cyc%0d", c), outs(), e);
      if (mmode == 0) begin
        if (blk_valid_i) begin
          mmode = 1;
          mk = 1;
          mf = first_blk_i;
          ml = last_blk_i;
        end
      end else if (mmode == 1) begin
        if (abort_i) mmode = 0;
        else if (mk == 66) mmode = ml ? 2 : 0;
        else mk++;
      end else if (digest_ack_i) begin
        mmode = 0;
      end
    end
    blk_valid_i = 1'b0;
    abort_i = 1'b0;
    digest_ack_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath. It accepts one 512-bit message block at a time through a valid/ready handshake and drives the load enables (`start`) of the eight 32-bit working registers a..h and the eight hash registers H0..H7. It also drives the round index for the K constant ROM and the message-schedule controls. It sits between the padding/message front end and the register/round-logic datapath, and flags a finished digest after the last block of a message.

## Interface

No parameters: the round count is fixed at 64 and the schedule split is fixed at 16.

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- blk_valid_i  in  1  a message block is present on the front-end bus
- first_blk_i  in  1  the offered block is the first block of a message; sampled on accept
- last_blk_i  in  1  the offered block is the last block of a message; sampled on accept
- blk_ready_o  out  1  controller can accept a block
- msg_load_o  out  1  load the 16 schedule words from the bus (accept strobe)
- abort_i  in  1  synchronous abort of the block in progress
- reg_start_o  out  1  `start` enable for working registers a..h
- init_sel_o  out  1  working-register input mux: 1 = H0..H7 (initialise), 0 = round logic
- hash_init_o  out  1  load H0..H7 with the SHA-256 IV
- hash_upd_o  out  1  load H0..H7 with Hi + working register
- round_o  out  6  current round t, 0..63
- w_sel_o  out  1  schedule word source: 0 = stored message word (t<16), 1 = computed σ-expansion
- w_shift_o  out  1  advance the message-schedule window
- busy_o  out  1  state is not IDLE
- digest_valid_o  out  1  H0..H7 hold a final digest
- digest_ack_i  in  1  consumer has taken the digest

## Operation

States:

- IDLE: blk_ready_o=1.
  - On accept (blk_valid_i & blk_ready_o): msg_load_o=1 combinationally; latch first_q←first_blk_i and last_q←last_blk_i.
  - Go to INIT.
- INIT (1 cycle): hash_init_o=first_q.
  - The working registers must load the IV on a first block, but H is not yet IV in that cycle. The datapath therefore muxes IV onto the H0..H7 outputs when hash_init_o=1, and the working registers load that value.
  - reg_start_o=1, init_sel_o=1.
  - Go to ROUND with t=0.
- ROUND (64 cycles): reg_start_o=1, init_sel_o=0, round_o=t, w_sel_o=(t>=16), w_shift_o=1.
  - t increments each cycle.
  - At t=63, go to UPDATE and t wraps to 0.
- UPDATE (1 cycle): hash_upd_o=1.
  - If last_q, go to DONE; otherwise go to IDLE.
- DONE: digest_valid_o=1, held until digest_ack_i=1, then go to IDLE.

Common rules:

- reg_start_o, hash_init_o, hash_upd_o, w_shift_o and msg_load_o are 0 in every state not listed above. While these enables are 0, the registers hold their value.
- abort_i:
  - In INIT, ROUND or UPDATE: the next state is IDLE, and t and the latched flags are cleared.
  - abort_i suppresses hash_upd_o in the same cycle (hash_upd_o = UPDATE & ~abort_i). H0..H7 are then unchanged from before the block, except after an INIT with hash_init_o, where H0..H7 hold the IV.
  - abort_i is ignored in IDLE and DONE.
- digest_ack_i outside DONE is ignored.
- blk_valid_i outside IDLE is ignored; blk_ready_o=0 outside IDLE.
- round_o is 6-bit unsigned, wrapping 63→0. It reads 0 in every state except ROUND.

## Timing

- Reset: RST high clears the state to IDLE and t, first_q and last_q to 0, asynchronously.
  - While RST=1, blk_ready_o and msg_load_o are forced to 0.
  - All other outputs are 0 during reset.
  - After RST deasserts, blk_ready_o reads 1.
- Reset mid-operation: the block is abandoned, outputs drop to their reset values immediately, and no hash_upd_o is issued.
- Accept at cycle 0:
  - INIT at cycle 1.
  - ROUND at cycles 2..65, with round_o=0..63.
  - UPDATE at cycle 66.
  - Cycle 67 is DONE (last block) or IDLE (not last).
- Back-to-back non-last blocks: the next accept is possible at cycle 67, giving a throughput of 67 cycles per block.
- digest_valid_o rises at cycle 67. The ack cycle is the last cycle of DONE, and IDLE follows one cycle later. An ack already high in the first DONE cycle gives a 1-cycle DONE.
- All outputs except msg_load_o and hash_upd_o are decoded from registered state only; those two also depend on same-cycle inputs as defined above.

## Test plan

- Single-block message "abc": reset, then offer blk_valid_i=1 with first=last=1.
  - Expect a msg_load_o pulse at cycle 0, hash_init_o=1 at cycle 1, and round_o stepping 0..63 at cycles 2..65.
  - Expect w_sel_o rising at round 16, hash_upd_o at cycle 66, and digest_valid_o from cycle 67.
  - H0..H7 must equal ba7816bf…f20015ad.
- Two-block message (first=1/last=0, then first=0/last=1, offered continuously):
  - Second accept at cycle 67.
  - No digest_valid_o after block 1.
  - digest_valid_o at cycle 134.
  - hash_init_o asserted only once.
- Digest hold: withhold digest_ack_i for 10 cycles.
  - digest_valid_o and blk_ready_o=0 held throughout.
  - An ack returns the state to IDLE on the next cycle, with blk_ready_o=1.
- Abort: assert abort_i at round_o=30.
  - Next cycle: IDLE, round_o=0, no hash_upd_o, H unchanged.
  - Also assert abort_i in the UPDATE cycle: hash_upd_o stays 0.
- Async reset at round_o=40: all outputs 0 immediately.
  - blk_valid_i held high during RST causes no msg_load_o.
  - After release, blk_ready_o=1 and a fresh block completes normally.
